// File: rtl/bus_fifo.sv
// bus_fifo: queues address/data/byte-select bus transfers between a master
// and a slower slave, with valid/ready handshakes on both sides. Depth is a
// power of two so the read and write pointers wrap for free. The occupancy
// count is kept explicitly, which tells full apart from empty without
// spending a wrap bit on each pointer.
module bus_fifo #(
   parameter int AW    = 32,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     s_vld,
   output logic                     s_rdy,
   input  logic [AW-1:0]            s_adr,
   input  logic [DW-1:0]            s_dat,
   input  logic [DW/8-1:0]          s_sel,
   output logic                     m_vld,
   input  logic                     m_rdy,
   output logic [AW-1:0]            m_adr,
   output logic [DW-1:0]            m_dat,
   output logic [DW/8-1:0]          m_sel,
   output logic [$clog2(DEPTH):0]   cnt
);

   localparam int SW = DW / 8;
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL = DEPTH[PW:0];

   // One stored transfer. The byte-select travels with its data unchanged,
   // so lanes whose select bit is clear are still stored as presented.
   typedef struct packed {
      logic [SW-1:0] sel;
      logic [AW-1:0] adr;
      logic [DW-1:0] dat;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        head;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW:0]   count_q;
   logic          push;
   logic          pop;

   // Both ready and valid come only from the registered count. This keeps
   // m_rdy out of the s_rdy path and s_vld out of the m_vld path, which is
   // why a full buffer still refuses a push in the same cycle as a pop.
   assign s_rdy = (count_q != FULL);
   assign m_vld = (count_q != '0);
   assign push  = s_vld && s_rdy;
   assign pop   = m_vld && m_rdy;
   assign cnt   = count_q;

   // The head entry drives the master side directly from storage. The slot
   // under rd_ptr is never written while it is occupied, so the outputs hold
   // steady while the downstream stalls.
   assign head  = mem[rd_ptr];
   assign m_adr = head.adr;
   assign m_dat = head.dat;
   assign m_sel = head.sel;

   // Storage write: not reset, because stale contents are never visible
   // while the count says the slot is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {s_sel, s_adr, s_dat};
      end
   end

   // Pointer and count bookkeeping. Reset clears everything in the same edge
   // and overrides any handshake that happens to coincide with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_fifo.sv
// Testbench for bus_fifo: a directed vector table on the default instance,
// hand-written streaming and random-backpressure runs checked against a
// queue-based reference model, and a round-trip test of a wide, deep
// instance.
module tb_bus_fifo;

   logic        clk;
   logic        rst;
   logic        s_vld;
   logic        s_rdy;
   logic [31:0] s_adr;
   logic [31:0] s_dat;
   logic [3:0]  s_sel;
   logic        m_vld;
   logic        m_rdy;
   logic [31:0] m_adr;
   logic [31:0] m_dat;
   logic [3:0]  m_sel;
   logic [2:0]  cnt;

   logic        p_rst;
   logic        p_s_vld;
   logic        p_s_rdy;
   logic [11:0] p_s_adr;
   logic [63:0] p_s_dat;
   logic [7:0]  p_s_sel;
   logic        p_m_vld;
   logic        p_m_rdy;
   logic [11:0] p_m_adr;
   logic [63:0] p_m_dat;
   logic [7:0]  p_m_sel;
   logic [4:0]  p_cnt;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } rec_t;

   typedef struct {
      logic        rst;
      logic        vld;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic        rdy;
      logic        e_vld;
      logic [2:0]  e_cnt;
      logic        e_srdy;
      logic [31:0] e_adr;
      logic [31:0] e_dat;
      logic [3:0]  e_sel;
   } vec_t;

   rec_t q[$];
   vec_t vecs[$];
   logic last_push;

   bus_fifo dut (
      .clk   (clk),
      .rst   (rst),
      .s_vld (s_vld),
      .s_rdy (s_rdy),
      .s_adr (s_adr),
      .s_dat (s_dat),
      .s_sel (s_sel),
      .m_vld (m_vld),
      .m_rdy (m_rdy),
      .m_adr (m_adr),
      .m_dat (m_dat),
      .m_sel (m_sel),
      .cnt   (cnt)
   );

   bus_fifo #(.AW(12), .DW(64), .DEPTH(16)) dut_wide (
      .clk   (clk),
      .rst   (p_rst),
      .s_vld (p_s_vld),
      .s_rdy (p_s_rdy),
      .s_adr (p_s_adr),
      .s_dat (p_s_dat),
      .s_sel (p_s_sel),
      .m_vld (p_m_vld),
      .m_rdy (p_m_rdy),
      .m_adr (p_m_adr),
      .m_dat (p_m_dat),
      .m_sel (p_m_sel),
      .cnt   (p_cnt)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic void checkValue(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic vec_t mk(input logic r, input logic v, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] s, input logic rd,
                               input logic ev, input logic [2:0] ec, input logic es,
                               input logic [31:0] ea, input logic [31:0] ed,
                               input logic [3:0] esl);
      vec_t t;
      t.rst = r;    t.vld = v;     t.adr = a;     t.dat = d;
      t.sel = s;    t.rdy = rd;    t.e_vld = ev;  t.e_cnt = ec;
      t.e_srdy = es; t.e_adr = ea; t.e_dat = ed;  t.e_sel = esl;
      return t;
   endfunction

   // Drive one cycle of inputs at the falling edge, advance the reference
   // queue at the rising edge, and return at the next falling edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [31:0] a,
                                input logic [31:0] d, input logic [3:0] s, input logic rd);
      logic do_pop;
      logic do_push;
      rec_t rec;
      rst   = r;
      s_vld = v;
      s_adr = a;
      s_dat = d;
      s_sel = s;
      m_rdy = rd;
      @(posedge clk);
      do_pop  = 1'b0;
      do_push = 1'b0;
      if (r) begin
         q.delete();
      end else begin
         do_pop  = rd && (q.size() != 0);
         do_push = v && (q.size() != 4);
         if (do_pop) begin
            void'(q.pop_front());
         end
         if (do_push) begin
            rec.adr = a;
            rec.dat = d;
            rec.sel = s;
            q.push_back(rec);
         end
      end
      last_push = do_push;
      @(negedge clk);
   endtask

   // Compare the default instance against the reference queue.
   task automatic checkOutput();
      checkValue("cnt", 64'(cnt), 64'(q.size()));
      checkValue("cnt_range", 64'(cnt <= 3'd4), 64'd1);
      checkValue("m_vld", 64'(m_vld), 64'(q.size() != 0));
      checkValue("s_rdy", 64'(s_rdy), 64'(q.size() != 4));
      if (q.size() != 0) begin
         checkValue("m_adr", 64'(m_adr), 64'(q[0].adr));
         checkValue("m_dat", 64'(m_dat), 64'(q[0].dat));
         checkValue("m_sel", 64'(m_sel), 64'(q[0].sel));
      end
   endtask

   // Main sequence.
   initial begin
      logic        pend;
      rec_t        pr;
      logic [11:0] w_adr [16];
      logic [63:0] w_dat [16];

      p_rst   = 1'b1;
      p_s_vld = 1'b0;
      p_s_adr = '0;
      p_s_dat = '0;
      p_s_sel = '0;
      p_m_rdy = 1'b0;
      last_push = 1'b0;

      vecs.push_back(mk(1, 1, 32'h55, 32'h55, 4'hF, 0, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h55, 32'h55, 4'hF, 0, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0,
                        1, 3'd1, 1, 32'h1000, 32'hDEADBEEF, 4'hF));
      for (int i = 0; i < 5; i++) begin
         vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3'd1, 1, 32'h1000, 32'hDEADBEEF, 4'hF));
      end
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0, 0, 0));
      for (int i = 0; i < 4; i++) begin
         vecs.push_back(mk(0, 1, 32'(i), 32'hA0 + 32'(i), 4'hF, 0,
                           1, 3'(i + 1), (i != 3), 32'h0, 32'hA0, 4'hF));
      end
      vecs.push_back(mk(0, 1, 32'h4, 32'hA4, 4'hF, 1, 1, 3'd3, 1, 32'h1, 32'hA1, 4'hF));
      vecs.push_back(mk(0, 1, 32'h4, 32'hA4, 4'hF, 0, 1, 3'd4, 0, 32'h1, 32'hA1, 4'hF));
      vecs.push_back(mk(1, 1, 32'h5, 32'hA5, 4'hF, 1, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(1, 1, 32'h5, 32'hA5, 4'hF, 1, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 32'h77, 32'h77, 4'h3, 1, 1, 3'd1, 1, 32'h77, 32'h77, 4'h3));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 3'd0, 1, 0, 0, 0));

      foreach (vecs[k]) begin
         applyStimulus(vecs[k].rst, vecs[k].vld, vecs[k].adr, vecs[k].dat,
                       vecs[k].sel, vecs[k].rdy);
         checkOutput();
         checkValue($sformatf("vec%0d cnt", k), 64'(cnt), 64'(vecs[k].e_cnt));
         checkValue($sformatf("vec%0d m_vld", k), 64'(m_vld), 64'(vecs[k].e_vld));
         checkValue($sformatf("vec%0d s_rdy", k), 64'(s_rdy), 64'(vecs[k].e_srdy));
         if (vecs[k].e_vld) begin
            checkValue($sformatf("vec%0d m_adr", k), 64'(m_adr), 64'(vecs[k].e_adr));
            checkValue($sformatf("vec%0d m_dat", k), 64'(m_dat), 64'(vecs[k].e_dat));
            checkValue($sformatf("vec%0d m_sel", k), 64'(m_sel), 64'(vecs[k].e_sel));
         end
      end

      $display("[TB] streaming 20 back-to-back transfers");
      for (int i = 0; i < 20; i++) begin
         applyStimulus(0, 1, 32'(i), 32'h100 + 32'(i), 4'hF, 1);
         checkOutput();
         checkValue("stream m_vld", 64'(m_vld), 64'd1);
         checkValue("stream head", 64'(m_adr), 64'(i));
         checkValue("stream cnt<=1", 64'(cnt <= 3'd1), 64'd1);
      end
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput();
      checkValue("stream drained", 64'(cnt), 64'd0);

      $display("[TB] random backpressure, 10000 cycles");
      pend = 1'b0;
      pr   = '0;
      for (int i = 0; i < 10000; i++) begin
         if (!pend && ($urandom_range(0, 3) != 0)) begin
            pend   = 1'b1;
            pr.adr = $urandom;
            pr.dat = $urandom;
            pr.sel = 4'($urandom);
         end
         applyStimulus(0, pend, pr.adr, pr.dat, pr.sel, 1'($urandom_range(0, 1)));
         checkOutput();
         if (last_push) begin
            pend = 1'b0;
         end
      end
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 1);
         checkOutput();
      end
      checkValue("random drained", 64'(cnt), 64'd0);

      $display("[TB] wide instance AW=12 DW=64 DEPTH=16");
      @(posedge clk);
      @(negedge clk);
      p_rst = 1'b0;
      checkValue("wide reset cnt", 64'(p_cnt), 64'd0);
      checkValue("wide reset s_rdy", 64'(p_s_rdy), 64'd1);
      checkValue("wide reset m_vld", 64'(p_m_vld), 64'd0);
      for (int i = 0; i < 16; i++) begin
         w_adr[i] = 12'($urandom) ^ 12'(i);
         w_dat[i] = {$urandom, $urandom};
         p_s_vld  = 1'b1;
         p_s_adr  = w_adr[i];
         p_s_dat  = w_dat[i];
         p_s_sel  = 8'h5A;
         @(posedge clk);
         @(negedge clk);
         checkValue("wide fill cnt", 64'(p_cnt), 64'(i + 1));
      end
      checkValue("wide full s_rdy", 64'(p_s_rdy), 64'd0);
      p_s_adr = 12'hFFF;
      @(posedge clk);
      @(negedge clk);
      checkValue("wide refused cnt", 64'(p_cnt), 64'd16);
      p_s_vld = 1'b0;
      p_m_rdy = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checkValue("wide m_vld", 64'(p_m_vld), 64'd1);
         checkValue("wide m_adr", 64'(p_m_adr), 64'(w_adr[i]));
         checkValue("wide m_dat", p_m_dat, w_dat[i]);
         checkValue("wide m_sel", 64'(p_m_sel), 64'h5A);
         @(posedge clk);
         @(negedge clk);
      end
      checkValue("wide empty cnt", 64'(p_cnt), 64'd0);
      checkValue("wide empty m_vld", 64'(p_m_vld), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
